timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel counter/timer, the successor to the single fixed-width free-running LED counter. Each of NUM_CH channels counts sys_clk cycles up to a runtime-loadable period, emits a one-cycle terminal-count pulse, toggles a square-wave output and runs either periodic or one-shot. It sits between the system clock/reset and any blink, tick or timeout consumers.

## Interface
- CNT_W, 26, counter and period width per channel
- NUM_CH, 2, number of independent channels
- DEF_PERIOD, 49_999_999, period loaded at reset (1 s at 50 MHz); must fit CNT_W
- sys_clk  in  1  single clock, rising edge
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- en  in  NUM_CH  per-channel count enable; low pauses the count
- mode  in  NUM_CH  0 = periodic, 1 = one-shot
- start  in  NUM_CH  one-shot trigger pulse; ignored in periodic mode
- load  in  NUM_CH  latch period_i slice into the period register and restart the count
- period_i  in  NUM_CH*CNT_W  new periods, channel k at [k*CNT_W +: CNT_W]
- cnt  out  NUM_CH*CNT_W  current count, same packing
- tc  out  NUM_CH  one-cycle terminal-count pulse
- out  out  NUM_CH  toggles on every tc
- busy  out  NUM_CH  high while the channel is in RUN

## Operation
- Per channel, a two-state FSM: IDLE, RUN. busy = (state == RUN).
- IDLE -> RUN: if mode=0 and en=1, or if mode=1 and start=1. Count restarts from 0.
- RUN with en=1 and cnt != period_r: cnt increments by 1.
- RUN with en=1 and cnt == period_r: terminal event. cnt goes to 0, tc=1 for one cycle and out inverts. With mode=0 the channel stays in RUN. With mode=1 it goes to IDLE.
- RUN with en=0: cnt, out and state hold. tc=0.
- Period N gives a tc every N+1 enabled cycles. With period 0 a periodic channel pulses tc every enabled cycle.
- load (highest priority, any state): period_r takes period_i, cnt goes to 0 and the state is unchanged. No tc in that cycle, even if a terminal count coincides.
- start while in RUN in one-shot mode: retrigger. cnt goes to 0 and no tc. load takes precedence.
- mode is sampled only at the terminal event and at IDLE exit. A mid-run change does not disturb the count.
- IDLE: cnt holds 0 and tc=0.
- Arithmetic is unsigned CNT_W bits. cnt never exceeds period_r, so there is no overflow wrap.
- Channels are fully independent. There is no cross-channel priority.

## Timing
- Reset values: cnt=0, tc=0, out=0, busy=0, period_r=DEF_PERIOD, FSM=IDLE. pwm=0 when the PWM feature is compiled in.
- Asserting sys_rst_n low forces the reset values immediately, with no clock edge, including mid-count.
- All outputs are registered.
- tc, the cnt wrap to 0 and the out toggle all appear in the cycle after the edge that sampled cnt == period_r with en=1.
- start and load act on the next edge. The first increment is visible one cycle after the restart.
- A channel that became busy leaves IDLE one edge after its trigger is sampled.

## Configuration
- TIMER_BANK_PWM_EN: when defined, adds two ports, duty_i (in, NUM_CH*CNT_W) and pwm (out, NUM_CH).
- pwm is registered and equals (busy && cnt < duty_r).
- duty_r is latched from duty_i on load and reset to 0.
- duty 0 gives constant low. duty > period_r gives constant high while busy.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package timer_bank_pkg holds:
  - the state enum (IDLE, RUN)
  - the mode constants MODE_PERIODIC=0 and MODE_ONESHOT=1
  - a helper for slice offset k*CNT_W
- One sub-module, timer_channel, implements a single channel: FSM, counter, period/duty registers, tc/out/pwm.
- timer_bank only generates NUM_CH instances and packs and unpacks the vectors.

## Test plan
- Bench parameters: CNT_W=8, NUM_CH=2, DEF_PERIOD=9.
- Periodic ch0: release reset, en=1, mode=0. Required: cnt cycles 0..9, tc every 10 cycles, out toggles per tc, busy=1.
- One-shot ch1: load period 4, then pulse start. Required: busy for 5 cycles and exactly one tc. Afterwards cnt=0, busy=0 and out has toggled once.
- Pause ch0: drop en at cnt=5 for 3 cycles. Required: cnt holds 5 and the next tc arrives 3 cycles late.
- Period 0 on ch0: load period 0. Required: tc high every enabled cycle and out toggles every cycle.
- Coincident load: load period 3 in the same cycle cnt == 9. Required: no tc, cnt=0, then tc after 4 cycles.
- Async reset: assert reset at cnt=7 between clock edges. Required: all outputs return to reset values immediately.
- PWM (with TIMER_BANK_PWM_EN): duty 3, period 9. Required: pwm high for 3 of every 10 cycles.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared types and helpers for the timer_bank channel array.
// Optional PWM output is enabled by defining TIMER_BANK_PWM_EN.
package timer_bank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Low bit index of channel k inside a packed NUM_CH*w vector.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM, counter, period register, tc/out pulses.
// With TIMER_BANK_PWM_EN defined it also carries a duty register and pwm output.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int               CNT_W      = 26,
    parameter logic [CNT_W-1:0] DEF_PERIOD = {CNT_W{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_i,
`ifdef TIMER_BANK_PWM_EN
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
`endif
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o,
    output logic             out_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             out_q, out_d;
    logic             tc_q, tc_d;
    logic             busy_q;
`ifdef TIMER_BANK_PWM_EN
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
`endif

    // Next-state logic: load overrides everything, then retrigger, pause, terminal, count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        out_d    = out_q;
        tc_d     = 1'b0;
`ifdef TIMER_BANK_PWM_EN
        duty_d   = duty_q;
`endif
        if (load_i) begin
            period_d = period_i;
            cnt_d    = CNT_ZERO;
`ifdef TIMER_BANK_PWM_EN
            duty_d   = duty_i;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = CNT_ZERO;
                    if (((mode_i == MODE_PERIODIC) && en_i) ||
                        ((mode_i == MODE_ONESHOT) && start_i)) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if ((mode_i == MODE_ONESHOT) && start_i) begin
                        cnt_d = CNT_ZERO;
                    end else if (!en_i) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == period_q) begin
                        cnt_d = CNT_ZERO;
                        tc_d  = 1'b1;
                        out_d = ~out_q;
                        if (mode_i == MODE_ONESHOT) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
`ifdef TIMER_BANK_PWM_EN
        // Judged on next-state values so the registered pwm lines up with cnt.
        pwm_d = (state_d == RUN) && (cnt_d < duty_d);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            period_q <= DEF_PERIOD;
            out_q    <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef TIMER_BANK_PWM_EN
            duty_q   <= CNT_ZERO;
            pwm_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            out_q    <= out_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN);
`ifdef TIMER_BANK_PWM_EN
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
`endif
        end
    end

    assign cnt_o  = cnt_q;
    assign tc_o   = tc_q;
    assign out_o  = out_q;
    assign busy_o = busy_q;
`ifdef TIMER_BANK_PWM_EN
    assign pwm_o  = pwm_q;
`endif

endmodule

// File: rtl/timer_bank.sv
// NUM_CH independent timer channels with packed per-channel vectors.
// Define TIMER_BANK_PWM_EN to add duty_i/pwm ports.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          CNT_W      = 26,
    parameter int          NUM_CH     = 2,
    parameter int unsigned DEF_PERIOD = 49_999_999
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
`ifdef TIMER_BANK_PWM_EN
    input  logic [NUM_CH*CNT_W-1:0] duty_i,
    output logic [NUM_CH-1:0]       pwm,
`endif
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       out,
    output logic [NUM_CH-1:0]       busy
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int LO = slice_lo(k, CNT_W);

        timer_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_P)
        ) u_ch (
            .clk_i    (sys_clk),
            .rst_ni   (sys_rst_n),
            .en_i     (en[k]),
            .mode_i   (mode[k]),
            .start_i  (start[k]),
            .load_i   (load[k]),
            .period_i (period_i[LO +: CNT_W]),
`ifdef TIMER_BANK_PWM_EN
            .duty_i   (duty_i[LO +: CNT_W]),
            .pwm_o    (pwm[k]),
`endif
            .cnt_o    (cnt[LO +: CNT_W]),
            .tc_o     (tc[k]),
            .out_o    (out[k]),
            .busy_o   (busy[k])
        );
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with CNT_W=8, NUM_CH=2, DEF_PERIOD=9.
module tb_timer_bank;

    logic        clk;
    logic        rst_n;
    logic [1:0]  en, mode, start, load;
    logic [15:0] period_i;
    logic [15:0] cnt;
    logic [1:0]  tc, out, busy;
`ifdef TIMER_BANK_PWM_EN
    logic [15:0] duty_i;
    logic [1:0]  pwm;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    timer_bank #(.CNT_W(8), .NUM_CH(2), .DEF_PERIOD(9)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .en        (en),
        .mode      (mode),
        .start     (start),
        .load      (load),
        .period_i  (period_i),
`ifdef TIMER_BANK_PWM_EN
        .duty_i    (duty_i),
        .pwm       (pwm),
`endif
        .cnt       (cnt),
        .tc        (tc),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({cnt, tc, out, busy} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_values: got cnt=%h tc=%b out=%b busy=%b required all zero", cnt, tc, out, busy);
        end
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (busy !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_en: got busy=%b required 00", busy);
        end
    endtask

    task automatic test_periodic();
        en = 2'b01;
        mode = 2'b00;
        for (int i = 0; i < 30; i++) begin
            step();
            n_tests++;
            if (cnt[7:0] !== 8'(i % 10) || tc[0] !== ((i % 10 == 0) && (i != 0)) ||
                out[0] !== 1'((i / 10) % 2) || busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic[%0d]: got cnt=%0d tc=%b out=%b busy=%b required cnt=%0d", i, cnt[7:0], tc[0], out[0], busy[0], i % 10);
            end
        end
    endtask

    task automatic test_pause();
        int n;
        bit found;
        repeat (6) step();
        n_tests++;
        if (cnt[7:0] !== 8'd5 || out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_pre: got cnt=%0d out=%b required 5 1", cnt[7:0], out[0]);
        end
        en[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            n_tests++;
            if (cnt[7:0] !== 8'd5 || tc[0] !== 1'b0 || busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_hold[%0d]: got cnt=%0d tc=%b busy=%b required 5 0 1", j, cnt[7:0], tc[0], busy[0]);
            end
        end
        en[0] = 1'b1;
        n = 3;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            step();
            n++;
            if (tc[0]) found = 1'b1;
        end
        n_tests++;
        if (n != 8 || cnt[7:0] !== 8'd0 || out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_tc_delay: got %0d cycles cnt=%0d out=%b required 8 0 0", n, cnt[7:0], out[0]);
        end
    endtask

    task automatic test_coincident();
        repeat (9) step();
        n_tests++;
        if (cnt[7:0] !== 8'd9 || tc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_pre: got cnt=%0d tc=%b required 9 0", cnt[7:0], tc[0]);
        end
        period_i[7:0] = 8'd3;
        load = 2'b01;
        step();
        load = 2'b00;
        n_tests++;
        if (tc[0] !== 1'b0 || cnt[7:0] !== 8'd0 || out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_load: got tc=%b cnt=%0d out=%b required 0 0 0", tc[0], cnt[7:0], out[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_tests++;
            if (cnt[7:0] !== 8'(k % 4) || tc[0] !== (k == 4) || out[0] !== (k == 4)) begin
                n_fail++;
                $display("FAIL coinc_run[%0d]: got cnt=%0d tc=%b out=%b required cnt=%0d", k, cnt[7:0], tc[0], out[0], k % 4);
            end
        end
    endtask

    task automatic test_period0();
        period_i[7:0] = 8'd0;
        load = 2'b01;
        step();
        load = 2'b00;
        n_tests++;
        if (tc[0] !== 1'b0 || cnt[7:0] !== 8'd0 || out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL p0_load: got tc=%b cnt=%0d out=%b required 0 0 1", tc[0], cnt[7:0], out[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_tests++;
            if (tc[0] !== 1'b1 || cnt[7:0] !== 8'd0 || out[0] !== (k % 2 == 0)) begin
                n_fail++;
                $display("FAIL p0_run[%0d]: got tc=%b cnt=%0d out=%b required 1 0 %0d", k, tc[0], cnt[7:0], out[0], (k % 2 == 0));
            end
        end
    endtask

    task automatic test_oneshot();
        int busy_cnt;
        int tc_cnt;
        en[1] = 1'b1;
        mode[1] = 1'b1;
        period_i[15:8] = 8'd4;
        load = 2'b10;
        step();
        load = 2'b00;
        n_tests++;
        if (cnt[15:8] !== 8'd0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL os_load: got cnt=%0d busy=%b required 0 0", cnt[15:8], busy[1]);
        end
        start = 2'b10;
        step();
        start = 2'b00;
        n_tests++;
        if (busy[1] !== 1'b1 || cnt[15:8] !== 8'd0) begin
            n_fail++;
            $display("FAIL os_start: got busy=%b cnt=%0d required 1 0", busy[1], cnt[15:8]);
        end
        busy_cnt = (busy[1] === 1'b1) ? 1 : 0;
        tc_cnt = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (busy[1] === 1'b1) busy_cnt++;
            if (tc[1] === 1'b1) tc_cnt++;
        end
        n_tests++;
        if (busy_cnt != 5 || tc_cnt != 1) begin
            n_fail++;
            $display("FAIL os_counts: got busy=%0d tc=%0d required 5 1", busy_cnt, tc_cnt);
        end
        n_tests++;
        if (cnt[15:8] !== 8'd0 || busy[1] !== 1'b0 || out[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL os_final: got cnt=%0d busy=%b out=%b required 0 0 1", cnt[15:8], busy[1], out[1]);
        end
    endtask

    task automatic test_async_reset();
        period_i[7:0] = 8'd9;
        load = 2'b01;
        step();
        load = 2'b00;
        repeat (7) step();
        n_tests++;
        if (cnt[7:0] !== 8'd7) begin
            n_fail++;
            $display("FAIL ar_pre: got cnt=%0d required 7", cnt[7:0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cnt, tc, out, busy} !== 22'h0) begin
            n_fail++;
            $display("FAIL ar_values: got cnt=%h tc=%b out=%b busy=%b required all zero", cnt, tc, out, busy);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            n_tests++;
            if (tc[0] !== (i == 10) || cnt[7:0] !== 8'(i % 10)) begin
                n_fail++;
                $display("FAIL ar_def_period[%0d]: got tc=%b cnt=%0d required tc=%0d cnt=%0d", i, tc[0], cnt[7:0], (i == 10), i % 10);
            end
        end
    endtask

`ifdef TIMER_BANK_PWM_EN
    task automatic test_pwm();
        int hi;
        period_i[7:0] = 8'd9;
        duty_i[7:0] = 8'd3;
        load = 2'b01;
        step();
        load = 2'b00;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            if (pwm[0] === 1'b1) hi++;
            n_tests++;
            if (pwm[0] !== ((i % 10) < 3)) begin
                n_fail++;
                $display("FAIL pwm[%0d]: got %b required %0d", i, pwm[0], ((i % 10) < 3));
            end
        end
        n_tests++;
        if (hi != 6) begin
            n_fail++;
            $display("FAIL pwm_high_count: got %0d required 6", hi);
        end
    endtask
`endif

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        en = 2'b00;
        mode = 2'b00;
        start = 2'b00;
        load = 2'b00;
        period_i = 16'h0000;
`ifdef TIMER_BANK_PWM_EN
        duty_i = 16'h0000;
`endif
        test_reset();
        test_periodic();
        test_pause();
        test_coincident();
        test_period0();
        test_oneshot();
        test_async_reset();
`ifdef TIMER_BANK_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
